// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the 16-bit CPU pipeline
//
// Purpose: datapath widths, the NOP encoding and the reset fetch address,
// shared by every pipeline block.
// Ports: none (package).
package cpu_pkg;
  localparam int          DATA_W    = 16;
  localparam int          REG_AW    = 4;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [15:0] RESET_PC  = 16'h0000;
endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - generic pipeline register with reset, clear and enable
//
// Purpose: one W-bit register. Priority: reset -> RST_VAL, clr_i -> CLR_VAL,
// en_i -> d_i, otherwise hold.
// Ports:
//   clk    in  1  clock, rising edge
//   reset  in  1  synchronous active-high reset
//   clr_i  in  1  load CLR_VAL (bubble)
//   en_i   in  1  load d_i
//   d_i    in  W  next value
//   q_o    out W  register contents
module pipe_reg #(
  parameter int           W       = 16,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (reset)      q_q <= RST_VAL;
    else if (clr_i) q_q <= CLR_VAL;
    else if (en_i)  q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/pipe_stage_regs.sv
// rtl/pipe_stage_regs.sv - PC, IF/ID and ID/EX registers with hazard control
//
// Purpose: holds the fetch PC and the IF/ID and ID/EX pipeline registers,
// applies stall/flush/branch-redirect commands from the hazard unit and keeps
// saturating stall and flush event counters for the debug path.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   stallF, stallD, flushD, flushE  hazard-unit commands
//   InstBranch, branchTarget        taken-branch redirect
//   instrF                          fetched instruction for pcF
//   pcF                             fetch address
//   instrD, pcPlus1D, validD        IF/ID contents
//   *D decoded inputs               controls/operands/addresses into ID/EX
//   *E outputs                      ID/EX contents
//   stallCnt, flushCnt, cntClear    performance counters and their clear
module pipe_stage_regs #(
  parameter int                DATA_W   = cpu_pkg::DATA_W,
  parameter int                REG_AW   = cpu_pkg::REG_AW,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(cpu_pkg::RESET_PC),
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              flushE,
  input  logic              InstBranch,
  input  logic [DATA_W-1:0] branchTarget,
  input  logic [DATA_W-1:0] instrF,
  output logic [DATA_W-1:0] pcF,
  output logic [DATA_W-1:0] instrD,
  output logic [DATA_W-1:0] pcPlus1D,
  output logic              validD,
  input  logic              RegWriteD,
  input  logic              MemToRegD,
  input  logic              MemWriteD,
  input  logic              immediateD,
  input  logic [3:0]        aluOpD,
  input  logic [DATA_W-1:0] srcData1D,
  input  logic [DATA_W-1:0] srcData2D,
  input  logic [DATA_W-1:0] immD,
  input  logic [REG_AW-1:0] srcAdd1D,
  input  logic [REG_AW-1:0] srcAdd2D,
  input  logic [REG_AW-1:0] destAddD,
  output logic              RegWriteE,
  output logic              MemToRegE,
  output logic              MemWriteE,
  output logic              immediateE,
  output logic              validE,
  output logic [3:0]        aluOpE,
  output logic [DATA_W-1:0] srcData1E,
  output logic [DATA_W-1:0] srcData2E,
  output logic [DATA_W-1:0] immE,
  output logic [REG_AW-1:0] srcAdd1E,
  output logic [REG_AW-1:0] srcAdd2E,
  output logic [REG_AW-1:0] destAddE,
  output logic [CNT_W-1:0]  stallCnt,
  output logic [CNT_W-1:0]  flushCnt,
  input  logic              cntClear
);
  import cpu_pkg::*;

  localparam int IFID_W = 2 * DATA_W + 1;
  localparam int IDEX_W = 9 + 3 * DATA_W + 3 * REG_AW;
  // A flushed IF/ID holds a NOP with pcPlus1D=0 and validD=0.
  localparam logic [IFID_W-1:0] IFID_CLR = {DATA_W'(NOP_INSTR), {DATA_W{1'b0}}, 1'b0};

  // ---------------- PC ----------------
  logic [DATA_W-1:0] pc_plus1;
  logic [DATA_W-1:0] pc_d;
  logic              pc_en;

  assign pc_plus1 = pcF + DATA_W'(1);      // wraps modulo 2^DATA_W
  // A taken branch always arrives with stallF set, so the redirect must
  // override the hold.
  assign pc_en    = InstBranch | ~stallF;
  assign pc_d     = InstBranch ? branchTarget : pc_plus1;

  pipe_reg #(.W(DATA_W), .RST_VAL(RESET_PC), .CLR_VAL('0)) u_pc (
    .clk(clk), .reset(reset), .clr_i(1'b0), .en_i(pc_en), .d_i(pc_d), .q_o(pcF)
  );

  // ---------------- IF/ID ----------------
  logic [IFID_W-1:0] ifid_d;
  logic [IFID_W-1:0] ifid_q;

  assign ifid_d = {instrF, pc_plus1, 1'b1};

  pipe_reg #(.W(IFID_W), .RST_VAL('0), .CLR_VAL(IFID_CLR)) u_ifid (
    .clk(clk), .reset(reset), .clr_i(flushD), .en_i(~stallD), .d_i(ifid_d), .q_o(ifid_q)
  );

  assign {instrD, pcPlus1D, validD} = ifid_q;

  // ---------------- ID/EX ----------------
  // No enable: a load-use stall is a stallD plus a flushE bubble here.
  logic [IDEX_W-1:0] idex_d;
  logic [IDEX_W-1:0] idex_q;

  assign idex_d = {RegWriteD, MemToRegD, MemWriteD, immediateD, validD, aluOpD,
                   srcData1D, srcData2D, immD, srcAdd1D, srcAdd2D, destAddD};

  pipe_reg #(.W(IDEX_W), .RST_VAL('0), .CLR_VAL('0)) u_idex (
    .clk(clk), .reset(reset), .clr_i(flushE), .en_i(1'b1), .d_i(idex_d), .q_o(idex_q)
  );

  assign {RegWriteE, MemToRegE, MemWriteE, immediateE, validE, aluOpE,
          srcData1E, srcData2E, immE, srcAdd1E, srcAdd2E, destAddE} = idex_q;

  // ---------------- performance counters ----------------
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc, flush_inc;

  // A stall overridden by a flush of the same stage is not counted as a stall.
  assign stall_inc = stallD & ~flushD;
  assign flush_inc = flushD | flushE;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cntClear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb/tb_pipe_stage_regs.sv - directed self-checking bench for pipe_stage_regs
module tb_pipe_stage_regs;
  logic        clk = 1'b0;
  logic        reset, stallF, stallD, flushD, flushE, InstBranch, cntClear;
  logic [15:0] branchTarget, instrF;
  logic [15:0] pcF, instrD, pcPlus1D;
  logic        validD;
  logic        RegWriteD, MemToRegD, MemWriteD, immediateD;
  logic [3:0]  aluOpD;
  logic [15:0] srcData1D, srcData2D, immD;
  logic [3:0]  srcAdd1D, srcAdd2D, destAddD;
  logic        RegWriteE, MemToRegE, MemWriteE, immediateE, validE;
  logic [3:0]  aluOpE;
  logic [15:0] srcData1E, srcData2E, immE;
  logic [3:0]  srcAdd1E, srcAdd2E, destAddE;
  logic [15:0] stallCnt, flushCnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_stage_regs dut (
    .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .flushE(flushE), .InstBranch(InstBranch),
    .branchTarget(branchTarget), .instrF(instrF), .pcF(pcF),
    .instrD(instrD), .pcPlus1D(pcPlus1D), .validD(validD),
    .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .MemWriteD(MemWriteD),
    .immediateD(immediateD), .aluOpD(aluOpD), .srcData1D(srcData1D),
    .srcData2D(srcData2D), .immD(immD), .srcAdd1D(srcAdd1D),
    .srcAdd2D(srcAdd2D), .destAddD(destAddD), .RegWriteE(RegWriteE),
    .MemToRegE(MemToRegE), .MemWriteE(MemWriteE), .immediateE(immediateE),
    .validE(validE), .aluOpE(aluOpE), .srcData1E(srcData1E),
    .srcData2E(srcData2E), .immE(immE), .srcAdd1E(srcAdd1E),
    .srcAdd2E(srcAdd2E), .destAddE(destAddE), .stallCnt(stallCnt),
    .flushCnt(flushCnt), .cntClear(cntClear)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_pcF"},      32'(pcF), 32'h0);
    chk({pfx, "_instrD"},   32'(instrD), 32'h0);
    chk({pfx, "_pcPlus1D"}, 32'(pcPlus1D), 32'h0);
    chk({pfx, "_validD"},   32'(validD), 32'h0);
    chk({pfx, "_ctrlE"},    32'({RegWriteE, MemToRegE, MemWriteE, immediateE, validE}), 32'h0);
    chk({pfx, "_dataE"},    32'({aluOpE, srcData1E ^ srcData2E ^ immE, srcAdd1E, srcAdd2E, destAddE}), 32'h0);
    chk({pfx, "_dataE_or"}, 32'(srcData1E | srcData2E | immE), 32'h0);
    chk({pfx, "_stallCnt"}, 32'(stallCnt), 32'h0);
    chk({pfx, "_flushCnt"}, 32'(flushCnt), 32'h0);
  endtask

  initial begin
    reset = 1; stallF = 0; stallD = 0; flushD = 0; flushE = 0;
    InstBranch = 0; cntClear = 0; branchTarget = 16'h0; instrF = 16'h1234;
    RegWriteD = 1; MemToRegD = 1; MemWriteD = 0; immediateD = 1; aluOpD = 4'h9;
    srcData1D = 16'hAAAA; srcData2D = 16'h5555; immD = 16'h00F0;
    srcAdd1D = 4'h1; srcAdd2D = 4'h2; destAddD = 4'h3;

    step(); step();
    chk_reset_state("rst0");

    // Free run: PC 0 -> 1 -> 2 -> 3
    reset = 0;
    step();
    chk("run1_pcF", 32'(pcF), 32'h1);
    chk("run1_instrD", 32'(instrD), 32'h1234);
    chk("run1_validD", 32'(validD), 32'h1);
    chk("run1_pcPlus1D", 32'(pcPlus1D), 32'h1);
    chk("run1_validE", 32'(validE), 32'h0);
    step();
    chk("run2_pcF", 32'(pcF), 32'h2);
    chk("run2_validE", 32'(validE), 32'h1);
    chk("run2_ctrlE", 32'({RegWriteE, MemToRegE, MemWriteE, immediateE, aluOpE}), 32'hD9);
    chk("run2_destAddE", 32'({srcAdd1E, srcAdd2E, destAddE}), 32'h123);
    chk("run2_srcData1E", 32'(srcData1E), 32'hAAAA);
    step();
    chk("run3_pcF", 32'(pcF), 32'h3);
    step(); step();
    chk("run5_pcF", 32'(pcF), 32'h5);
    chk("run5_pcPlus1D", 32'(pcPlus1D), 32'h5);

    // Load-use stall: stallF+stallD+flushE for one cycle at pcF=5
    instrF = 16'h5678; stallF = 1; stallD = 1; flushE = 1;
    step();
    stallF = 0; stallD = 0; flushE = 0;
    chk("lu_pcF", 32'(pcF), 32'h5);
    chk("lu_instrD", 32'(instrD), 32'h1234);
    chk("lu_pcPlus1D", 32'(pcPlus1D), 32'h5);
    chk("lu_validE", 32'(validE), 32'h0);
    chk("lu_RegWriteE", 32'(RegWriteE), 32'h0);
    chk("lu_MemToRegE", 32'(MemToRegE), 32'h0);
    chk("lu_stallCnt", 32'(stallCnt), 32'h1);
    chk("lu_flushCnt", 32'(flushCnt), 32'h1);

    // Taken branch with stallF/stallD/flushD
    InstBranch = 1; stallF = 1; stallD = 1; flushD = 1; branchTarget = 16'h0040;
    step();
    InstBranch = 0; stallF = 0; stallD = 0; flushD = 0;
    chk("br_pcF", 32'(pcF), 32'h0040);
    chk("br_instrD", 32'(instrD), 32'h0);
    chk("br_validD", 32'(validD), 32'h0);
    chk("br_pcPlus1D", 32'(pcPlus1D), 32'h0);
    chk("br_flushCnt", 32'(flushCnt), 32'h2);
    chk("br_stallCnt", 32'(stallCnt), 32'h1);
    step();
    chk("br1_pcF", 32'(pcF), 32'h0041);
    chk("br1_instrD", 32'(instrD), 32'h5678);
    chk("br1_validD", 32'(validD), 32'h1);
    chk("br1_validE", 32'(validE), 32'h0);

    // PC wrap from FFFF
    InstBranch = 1; branchTarget = 16'hFFFF;
    step();
    InstBranch = 0;
    chk("wrap0_pcF", 32'(pcF), 32'hFFFF);
    step();
    chk("wrap1_pcF", 32'(pcF), 32'h0000);
    chk("wrap1_pcPlus1D", 32'(pcPlus1D), 32'h0000);

    // Stall-counter saturation: from 1 up to FFFE, then 3 more cycles
    stallD = 1;
    repeat (16'hFFFD) step();
    chk("sat_pre_stallCnt", 32'(stallCnt), 32'hFFFE);
    step(); step(); step();
    chk("sat_stallCnt", 32'(stallCnt), 32'hFFFF);
    chk("sat_flushCnt", 32'(flushCnt), 32'h2);
    cntClear = 1;
    step();
    cntClear = 0;
    chk("clr_stallCnt", 32'(stallCnt), 32'h0);
    chk("clr_flushCnt", 32'(flushCnt), 32'h0);

    // flushD and flushE together count once; stallD under flushD does not count
    flushD = 1; flushE = 1;
    step();
    flushD = 0; flushE = 0; stallD = 0;
    chk("ff_flushCnt", 32'(flushCnt), 32'h1);
    chk("ff_stallCnt", 32'(stallCnt), 32'h0);
    chk("ff_validE", 32'(validE), 32'h0);

    // Reset during stall with validE=1
    step(); step();
    chk("pre_rst_validE", 32'(validE), 32'h1);
    stallD = 1; stallF = 1; InstBranch = 1; branchTarget = 16'h0077;
    step();
    chk("pre_rst_stallCnt", 32'(stallCnt), 32'h1);
    reset = 1;
    step();
    chk_reset_state("rst1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_stage_regs.md
# pipe_stage_regs

Pipeline-register block for the 16-bit CPU. It holds the PC register, the IF/ID register and the ID/EX register, and executes the stall, flush and branch-redirect commands issued by the hazard unit. It also keeps saturating stall and flush performance counters that the UART debug path reads. It sits between instruction fetch, decode and execute, and is the consumer of every hazard-unit control output.

## Interface
- DATA_W, 16, datapath and instruction width
- REG_AW, 4, register-address width
- RESET_PC, 16'h0000, PC value after reset
- CNT_W, 16, performance-counter width
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stallF, stallD  in  1 each  hold the PC / hold IF/ID
- flushD, flushE  in  1 each  bubble IF/ID / bubble ID/EX
- InstBranch  in  1  taken branch; redirect the PC
- branchTarget  in  DATA_W  redirect address
- instrF  in  DATA_W  instruction-memory read data for pcF
- pcF  out  DATA_W  current fetch address
- instrD, pcPlus1D  out  DATA_W each  IF/ID contents
- validD  out  1  IF/ID holds a real instruction
- RegWriteD, MemToRegD, MemWriteD, immediateD  in  1 each  decoded controls
- aluOpD  in  4  ALU operation
- srcData1D, srcData2D, immD  in  DATA_W each  decoded operands
- srcAdd1D, srcAdd2D, destAddD  in  REG_AW each  register addresses
- RegWriteE, MemToRegE, MemWriteE, immediateE, validE  out  1 each  ID/EX controls
- aluOpE  out  4
- srcData1E, srcData2E, immE  out  DATA_W each
- srcAdd1E, srcAdd2E, destAddE  out  REG_AW each
- stallCnt, flushCnt  out  CNT_W each  saturating event counters
- cntClear  in  1  synchronous clear of both counters

## Operation
- PC priority: reset → RESET_PC; else InstBranch → branchTarget, regardless of stallF; else stallF → hold; else pcF+1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
- IF/ID priority: reset → cleared; else flushD → instrD=16'h0000 (NOP), pcPlus1D=0, validD=0; else stallD → hold; else instrD=instrF, pcPlus1D=pcF+1, validD=1.
- ID/EX priority: reset → cleared; else flushE → all fields 0 and validE=0; else load all D-side inputs, with validE=validD. ID/EX has no stall; a load-use stall is expressed only as stallD plus flushE.
- A cleared or flushed ID/EX must have RegWriteE=MemToRegE=MemWriteE=0, so the bubble causes no side effect and no forward.
- stallCnt increments on each cycle in which stallD=1 and flushD=0. flushCnt increments on each cycle in which flushD or flushE is 1, by 1 even when both are set.
- Both counters saturate at all-ones. cntClear and reset zero them. cntClear takes priority over an increment in the same cycle.
- There is no state machine; each register is an independent prioritized enable/clear register.

## Timing
- Reset values: pcF=RESET_PC; every D/E output 0; validD=validE=0; counters 0.
- Latency: one cycle per stage. An instruction fetched at cycle n appears in instrD at n+1 and its controls appear at E at n+2 when there is no stall.
- Commands sampled at edge n take effect on outputs after edge n.
- If reset is asserted mid-stall or mid-branch, the reset values win in the same cycle.
- If stallD and flushD are both asserted, the flush wins.
- If InstBranch and stallF are both asserted, the redirect wins. This pairing always occurs on a taken branch.

## Structure
- Shared package cpu_pkg holds DATA_W, REG_AW, NOP_INSTR=16'h0000 and RESET_PC.
- One sub-module, pipe_reg: parameterized width, with clear > enable priority and a synchronous reset value. It is instantiated for the PC, IF/ID and ID/EX registers.
- The counters are inline.

## Test plan
- Reset, then free-run with instrF=16'h1234 → pcF goes 0,1,2,3; instrD=16'h1234 and validD=1 from the second cycle; validE=1 from the third.
- Hold stallF=stallD=1 and flushE=1 for 1 cycle at pcF=5 → pcF stays 5; instrD holds; validE=0 and RegWriteE=0 the next cycle; stallCnt=1; flushCnt=1.
- InstBranch=1, stallF=stallD=1, flushD=1, branchTarget=16'h0040 → pcF=16'h0040; instrD=0; validD=0; flushCnt increments.
- Set pcF to 16'hFFFF with no stall → the next pcF is 16'h0000.
- Preload stallCnt to 16'hFFFE, then hold stallD=1 for 3 cycles → stallCnt ends at 16'hFFFF. Then assert cntClear together with stallD → stallCnt=0.
- Assert reset during stallD=1 with validE=1 → all outputs match the reset values on the next cycle.
